// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI-style memory slave over an internal array of DEPTH 256-bit words.
// One write and one read burst may be in flight at once. Both channels run concurrently.
//
// Ports:
//   clk, rst              sole clock; synchronous active-high reset
//   axi_aw*               write address channel (byte address, beats-1)
//   axi_w*                write data channel
//   axi_b*                write response channel
//   axi_ar*               read address channel
//   axi_r*                read data channel
//   proto_err             sticky flag: wlast disagreed with the beat count of a write burst
//
// Build option: define AXI_RESP_RANGE_CHECK_EN to flag bursts that run past the end of memory
// or carry nonzero upper address bits. Such writes are dropped and answered with SLVERR, and
// such reads return zero data with SLVERR. Without it, indices simply wrap modulo DEPTH.
module axi_mem_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned B_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [39:0]  axi_awaddr,
    input  logic [7:0]   axi_awlen,
    input  logic         axi_awvalid,
    output logic         axi_awready,
    input  logic [255:0] axi_wdata,
    input  logic         axi_wlast,
    input  logic         axi_wvalid,
    output logic         axi_wready,
    output logic [1:0]   axi_bresp,
    output logic         axi_bvalid,
    input  logic         axi_bready,
    input  logic [39:0]  axi_araddr,
    input  logic [7:0]   axi_arlen,
    input  logic         axi_arvalid,
    output logic         axi_arready,
    output logic [255:0] axi_rdata,
    output logic [1:0]   axi_rresp,
    output logic         axi_rlast,
    output logic         axi_rvalid,
    input  logic         axi_rready,
    output logic         proto_err
);
    localparam int unsigned IW = $clog2(DEPTH);
    typedef logic [IW-1:0] idx_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

    logic [255:0] mem [DEPTH];

    // Low during the cycle after reset so the idle readies stay deasserted until rst drops.
    logic         run_q;

    w_state_e     w_state_q, w_state_d;
    idx_t         w_idx_q, w_idx_d;
    logic [7:0]   w_len_q, w_len_d;
    logic [7:0]   w_beat_q, w_beat_d;
    logic         w_err_q, w_err_d;
    logic [3:0]   w_wait_q, w_wait_d;
    logic         perr_q, perr_d;

    r_state_e     r_state_q, r_state_d;
    idx_t         r_idx_q, r_idx_d;
    logic [7:0]   r_len_q, r_len_d;
    logic [7:0]   r_beat_q, r_beat_d;
    logic         r_err_q, r_err_d;
    logic [255:0] rdata_q, rdata_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat, mem_we;
    logic aw_oor, ar_oor;
    logic unused_addr_bits;

`ifdef AXI_RESP_RANGE_CHECK_EN
    assign aw_oor = (|axi_awaddr[39:5+IW]) ||
                    ((32'(axi_awaddr[5+IW-1:5]) + 32'(axi_awlen)) > (DEPTH - 1));
    assign ar_oor = (|axi_araddr[39:5+IW]) ||
                    ((32'(axi_araddr[5+IW-1:5]) + 32'(axi_arlen)) > (DEPTH - 1));
    assign unused_addr_bits = ^{axi_awaddr[4:0], axi_araddr[4:0]};
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
    assign unused_addr_bits = ^{axi_awaddr[4:0], axi_awaddr[39:5+IW],
                                axi_araddr[4:0], axi_araddr[39:5+IW]};
`endif

    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;
    assign ar_hs       = axi_arvalid && axi_arready;
    assign r_hs        = axi_rvalid && axi_rready;
    assign w_last_beat = (w_beat_q == w_len_q);
    assign mem_we      = w_hs && !w_err_q && !rst;

    // ---------------- write channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 1'b0;
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            w_wait_q  <= '0;
            perr_q    <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            w_wait_q  <= w_wait_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        w_wait_d  = w_wait_q;
        perr_d    = perr_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_idx_d   = axi_awaddr[5+IW-1:5];
                    w_len_d   = axi_awlen;
                    w_beat_d  = '0;
                    w_err_d   = aw_oor;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_idx_d  = w_idx_q + idx_t'(1);
                    w_beat_d = w_beat_q + 8'd1;
                    // wlast must coincide exactly with the counted final beat.
                    if (axi_wlast != w_last_beat) begin
                        perr_d = 1'b1;
                    end
                    if (axi_wlast || w_last_beat) begin
                        w_wait_d  = '0;
                        w_state_d = (B_LATENCY > 1) ? W_WAIT : W_RESP;
                    end
                end
            end
            W_WAIT: begin
                if (w_wait_q == 4'(B_LATENCY - 2)) begin
                    w_state_d = W_RESP;
                end else begin
                    w_wait_d = w_wait_q + 4'd1;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        axi_awready = run_q && (w_state_q == W_IDLE);
        axi_wready  = (w_state_q == W_DATA);
        axi_bvalid  = (w_state_q == W_RESP);
        axi_bresp   = ((w_state_q == W_RESP) && w_err_q) ? 2'b10 : 2'b00;
        proto_err   = perr_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[w_idx_q] <= axi_wdata;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_err_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_beat_q  <= r_beat_d;
            r_err_q   <= r_err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_beat_d  = r_beat_q;
        r_err_d   = r_err_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_idx_d   = axi_araddr[5+IW-1:5];
                    r_len_d   = axi_arlen;
                    r_beat_d  = '0;
                    r_err_d   = ar_oor;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                // Reads the array before any same-edge write lands, so a collision sees old data.
                rdata_d   = r_err_q ? '0 : mem[r_idx_q];
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + idx_t'(1);
                        r_beat_d  = r_beat_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        axi_arready = run_q && (r_state_q == R_IDLE);
        axi_rvalid  = (r_state_q == R_DATA);
        axi_rlast   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
        axi_rresp   = ((r_state_q == R_DATA) && r_err_q) ? 2'b10 : 2'b00;
        axi_rdata   = rdata_q;
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned B_LATENCY = 3;

`ifdef AXI_RESP_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [39:0]  axi_awaddr;
    logic [7:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic         axi_wlast;
    logic         axi_wvalid;
    logic         axi_wready;
    logic [1:0]   axi_bresp;
    logic         axi_bvalid;
    logic         axi_bready;
    logic [39:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [255:0] axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;
    logic         proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: word array plus sticky protocol-error flag.
    logic [255:0] model [DEPTH];
    bit           exp_perr = 1'b0;

    axi_mem_responder #(
        .DEPTH     (DEPTH),
        .B_LATENCY (B_LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [39:0] rand_addr();
        logic [39:0] a;
        a = 40'($urandom_range(0, DEPTH - 1)) * 40'd32 + 40'($urandom_range(0, 31));
        if ($urandom_range(0, 5) == 0) a = a + (40'($urandom_range(1, 255)) << 30);
        return a;
    endfunction

    function automatic int word_index(input logic [39:0] addr);
        return int'((addr / 40'd32) % 40'(DEPTH));
    endfunction

    function automatic bit out_of_range(input logic [39:0] addr, input int len);
        bit hi;
        hi = (addr / (40'd32 * 40'(DEPTH))) != 0;
        return RANGE_CHK && (hi || (word_index(addr) + len > int'(DEPTH) - 1));
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic aw_hs(input logic [39:0] addr, input int len);
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awvalid = 1'b1;
        for (int t = 0; t < 20 && !axi_awready; t++) @(negedge clk);
        check_val("awready_wait", axi_awready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [39:0] addr, input int len);
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        axi_arvalid = 1'b1;
        for (int t = 0; t < 20 && !axi_arready; t++) @(negedge clk);
        check_val("arready_wait", axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_arvalid = 1'b0;
    endtask

    task automatic b_take(input logic [1:0] exp_resp);
        int lat;
        int h;
        lat = 1;
        while (!axi_bvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_val("b_latency", 256'(lat), 256'(B_LATENCY));
        check_val("bresp", axi_bresp, exp_resp);
        h = $urandom_range(0, 2);
        repeat (h) begin
            @(negedge clk);
            check_val("bvalid_hold", axi_bvalid, 1);
            check_val("bresp_hold", axi_bresp, exp_resp);
        end
        axi_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_bready = 1'b0;
        check_val("bvalid_clear", axi_bvalid, 0);
        check_val("awready_back", axi_awready, 1);
    endtask

    // mode 0: wlast on beat len; 1: wlast early on beat early_at; 2: wlast never driven.
    task automatic wr_burst(input logic [39:0] addr, input int len, input int mode,
                            input int early_at, input bit fixed, input logic [255:0] base);
        int idx;
        int nb;
        bit oor;
        logic [255:0] d;
        idx = word_index(addr);
        oor = out_of_range(addr, len);
        aw_hs(addr, len);
        nb = (mode == 1) ? early_at + 1 : len + 1;
        for (int b = 0; b < nb; b++) begin
            d = fixed ? base + 256'(b) : rand256();
            if ($urandom_range(0, 3) == 0) begin
                axi_wvalid = 1'b0;
                @(negedge clk);
            end
            axi_wdata  = d;
            axi_wvalid = 1'b1;
            axi_wlast  = (mode == 0 && b == len) || (mode == 1 && b == early_at);
            for (int t = 0; t < 20 && !axi_wready; t++) @(negedge clk);
            check_val("wready_wait", axi_wready, 1);
            check_val("aw_w_exclusive", axi_awready, 0);
            @(posedge clk);
            @(negedge clk);
            if (!oor) model[(idx + b) % DEPTH] = d;
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        if (mode != 0) exp_perr = 1'b1;
        b_take(oor ? 2'b10 : 2'b00);
        check_val("proto_err", proto_err, exp_perr);
    endtask

    // hold < 0 picks a random number of rready-low cycles per beat.
    task automatic rd_burst(input logic [39:0] addr, input int len, input int hold);
        int idx;
        int h;
        bit oor;
        logic [255:0] e;
        idx = word_index(addr);
        oor = out_of_range(addr, len);
        ar_hs(addr, len);
        for (int b = 0; b <= len; b++) begin
            e = oor ? '0 : model[(idx + b) % DEPTH];
            for (int t = 0; t < 10 && !axi_rvalid; t++) @(negedge clk);
            check_val("rvalid_wait", axi_rvalid, 1);
            check_val("rdata", axi_rdata, e);
            check_val("rlast", axi_rlast, (b == len));
            check_val("rresp", axi_rresp, oor ? 2'b10 : 2'b00);
            h = (hold < 0) ? $urandom_range(0, 2) : hold;
            repeat (h) begin
                axi_rready = 1'b0;
                @(negedge clk);
                check_val("rvalid_hold", axi_rvalid, 1);
                check_val("rdata_hold", axi_rdata, e);
                check_val("rlast_hold", axi_rlast, (b == len));
            end
            axi_rready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            axi_rready = 1'b0;
        end
        check_val("rvalid_clear", axi_rvalid, 0);
        check_val("arready_back", axi_arready, 1);
    endtask

    initial begin
        logic [255:0] d;
        logic [255:0] old;
        logic [39:0]  a;
        int           len;
        int           mode;
        int           early;
        int           r;

        rst         = 1'b1;
        axi_awaddr  = '0;
        axi_awlen   = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wlast   = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        axi_araddr  = '0;
        axi_arlen   = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_awready", axi_awready, 0);
        check_val("rst_wready", axi_wready, 0);
        check_val("rst_bvalid", axi_bvalid, 0);
        check_val("rst_arready", axi_arready, 0);
        check_val("rst_rvalid", axi_rvalid, 0);
        check_val("rst_rdata", axi_rdata, 0);
        check_val("rst_proto_err", proto_err, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("release_awready", axi_awready, 1);
        check_val("release_arready", axi_arready, 1);

        // Fill the whole array so every later read has a known expectation.
        wr_burst(40'h0, DEPTH - 1, 0, 0, 1'b0, '0);
        rd_burst(40'h0, DEPTH - 1, -1);

        // Single-beat write to word 20.
        wr_burst(40'h280, 0, 0, 0, 1'b1, 256'hCAFEBABE_DEADBEEF);
        rd_burst(40'h280, 0, 0);

        // Words 20..23 = 1..4, read back with rready alternating.
        wr_burst(40'h280, 3, 0, 0, 1'b1, 256'd1);
        rd_burst(40'h280, 3, 1);

        // Early wlast on the first beat of a two-beat burst.
        wr_burst(40'h400, 1, 1, 0, 1'b0, '0);
        rd_burst(40'h400, 1, 0);

        // Address just past the array: wraps, or is rejected with range checking.
        wr_burst(40'h800, 0, 0, 0, 1'b1, 256'h1234_5678);
        rd_burst(40'h0, 0, 0);
        rd_burst(40'h800, 0, 0);

        // Write beat and read fetch of word 30 on the same edge: read sees old data.
        old = model[30];
        d   = rand256();
        axi_awaddr  = 40'd30 * 40'd32;
        axi_awlen   = 8'd0;
        axi_awvalid = 1'b1;
        axi_araddr  = 40'd30 * 40'd32;
        axi_arlen   = 8'd0;
        axi_arvalid = 1'b1;
        axi_wdata   = d;
        axi_wvalid  = 1'b1;
        axi_wlast   = 1'b1;
        check_val("coll_awready", axi_awready, 1);
        check_val("coll_arready", axi_arready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_awvalid = 1'b0;
        axi_arvalid = 1'b0;
        check_val("coll_wready", axi_wready, 1);
        @(posedge clk);
        @(negedge clk);
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        model[30]  = d;
        check_val("coll_rvalid", axi_rvalid, 1);
        check_val("coll_rdata_old", axi_rdata, old);
        b_take(2'b00);
        check_val("coll_rdata_hold", axi_rdata, old);
        check_val("coll_rlast", axi_rlast, 1);
        axi_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        axi_rready = 1'b0;
        rd_burst(40'd30 * 40'd32, 0, 0);

        // Reset in the middle of a four-beat write, after two beats have landed.
        aw_hs(40'h100, 3);
        for (int b = 0; b < 2; b++) begin
            d          = rand256();
            axi_wdata  = d;
            axi_wvalid = 1'b1;
            axi_wlast  = 1'b0;
            check_val("midrst_wready", axi_wready, 1);
            @(posedge clk);
            @(negedge clk);
            model[8 + b] = d;
        end
        axi_wvalid = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_awready", axi_awready, 0);
        check_val("midrst_wready_low", axi_wready, 0);
        check_val("midrst_bvalid", axi_bvalid, 0);
        check_val("midrst_bresp", axi_bresp, 0);
        check_val("midrst_arready", axi_arready, 0);
        check_val("midrst_rvalid", axi_rvalid, 0);
        check_val("midrst_rlast", axi_rlast, 0);
        check_val("midrst_rresp", axi_rresp, 0);
        check_val("midrst_rdata", axi_rdata, 0);
        check_val("midrst_proto_err", proto_err, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_perr = 1'b0;
        check_val("postrst_awready", axi_awready, 1);
        check_val("postrst_arready", axi_arready, 1);
        check_val("postrst_bvalid", axi_bvalid, 0);
        check_val("postrst_proto_err", proto_err, 0);
        rd_burst(40'h100, 3, -1);

        // Randomized mix of bursts.
        for (int i = 0; i < 30; i++) begin
            a   = rand_addr();
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                mode  = 0;
                early = 0;
                r     = $urandom_range(0, 9);
                if (r == 0) begin
                    mode = 2;
                end else if (r == 1 && len >= 1) begin
                    mode  = 1;
                    early = $urandom_range(0, len - 1);
                end
                wr_burst(a, len, mode, early, 1'b0, '0);
            end else begin
                rd_burst(a, len, -1);
            end
        end
        rd_burst(40'h0, DEPTH - 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameter DEPTH, default 64, number of 256-bit words in internal memory (power of 2).
REQ-002 Parameter B_LATENCY, default 1, cycles from accepted wlast beat to bvalid assertion (range 1..15).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 axi_awaddr  input  40  write burst byte address; axi_awlen  input  8  beats-1; axi_awvalid  input  1; axi_awready  output  1.
REQ-006 axi_wdata  input  256; axi_wlast  input  1; axi_wvalid  input  1; axi_wready  output  1.
REQ-007 axi_bresp  output  2; axi_bvalid  output  1; axi_bready  input  1.
REQ-008 axi_araddr  input  40; axi_arlen  input  8; axi_arvalid  input  1; axi_arready  output  1.
REQ-009 axi_rdata  output  256; axi_rresp  output  2; axi_rlast  output  1; axi_rvalid  output  1; axi_rready  input  1.
REQ-010 proto_err  output  1  sticky flag, wlast/beat-count mismatch seen.

Function
REQ-011 Word index SHALL be addr[5+log2(DEPTH)-1:5]; addr[4:0] ignored; bursts are INCR, index +1 per beat, wrapping modulo DEPTH.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_WAIT, W_RESP.
REQ-013 W_IDLE: awready=1; on awvalid&&awready latch index and awlen, clear beat counter, go W_DATA next cycle.
REQ-014 W_DATA: wready=1; each wvalid&&wready writes wdata to memory at current index in that cycle's edge.
REQ-015 Burst SHALL end on beat number awlen+1 regardless of wlast; wlast early or missing at that beat SHALL set proto_err; early wlast also ends burst.
REQ-016 After final beat go W_WAIT for B_LATENCY-1 cycles (zero cycles if B_LATENCY=1), then W_RESP with bvalid=1.
REQ-017 W_RESP: bvalid and bresp held stable until bready; on bvalid&&bready return to W_IDLE; awready reasserts the following cycle.
REQ-018 Read FSM SHALL have states R_IDLE, R_FETCH, R_DATA; arready=1 only in R_IDLE.
REQ-019 On arvalid&&arready latch index/arlen, go R_FETCH; memory read is registered, rdata valid one cycle later in R_DATA with rvalid=1.
REQ-020 rvalid/rdata/rlast held stable until rready; on handshake advance index and go R_FETCH, or R_IDLE after beat arlen+1; rlast=1 only on final beat.
REQ-021 Read and write channels operate concurrently; same-cycle write and read of same word SHALL return pre-write data.
REQ-022 awready and wready never asserted together; at most one write and one read burst outstanding.
REQ-023 axi_rresp SHALL equal 2'b00 except as in REQ-030.

Reset
REQ-024 rst high at a clock edge SHALL force both FSMs to idle, mid-burst included, discarding in-flight bursts without response.
REQ-025 Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, proto_err=0; idle readies assert first cycle after rst deasserts.
REQ-026 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro AXI_RESP_RANGE_CHECK_EN selects address range checking.
REQ-028 Defined: burst whose start index plus len exceeds DEPTH-1, or addr[39:5+log2(DEPTH)] nonzero, is out of range.
REQ-029 Defined, write out of range: beats accepted but memory not written, bresp=2'b10 (SLVERR).
REQ-030 Defined, read out of range: rdata=0, rresp=2'b10 on every beat.
REQ-031 Undefined: no check, indices wrap per REQ-011, bresp=rresp=2'b00 always.

Verification
REQ-032 AW addr=0x280 len=0, one W beat 0xCAFEBABE_DEADBEEF wlast=1 -> mem[20] holds data, bvalid B_LATENCY cycles later, bresp=00.
REQ-033 AR addr=0x280 len=3 after writing mem[20..23]=1..4, rready toggling 1/0 -> rdata 1,2,3,4 in order, rlast only on 4, data stable while rready=0.
REQ-034 Write len=1 with wlast on beat 1 -> burst ends after one beat, proto_err=1, bvalid still issued.
REQ-035 With AXI_RESP_RANGE_CHECK_EN, DEPTH=64, write addr=0x800 -> bresp=10, memory unchanged; without macro -> mem[0] written, bresp=00.
REQ-036 Assert rst during W_DATA beat 2 of len=3 -> next cycle all outputs at reset values, awready=1 after release, proto_err=0.
